// File: rtl/audio_dsm_fifo_out_if.sv
// Bus interface for audio_dsm_fifo_out.
// Producer side: wreq/sample push frames and clr_flags clears the sticky flags.
// Consumer side: ready/level report FIFO state, sample_tick marks sample
// periods, underrun/overflow are sticky flags, dac_out is the 1-bit DAC output
// of each channel.
// slave  : the DAC block (drives status and dac_out)
// master : the frame producer (drives wreq/sample/clr_flags)
interface audio_dsm_fifo_out_if #(
  parameter int unsigned AUDIO_BITS = 12,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH = 8
) ();
  localparam int unsigned FRAME_W = CHANNELS * AUDIO_BITS;
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);

  logic               wreq;
  logic [FRAME_W-1:0] sample;
  logic               clr_flags;
  logic               ready;
  logic [LVL_W-1:0]   level;
  logic               sample_tick;
  logic               underrun;
  logic               overflow;
  logic [CHANNELS-1:0] dac_out;

  modport slave (
    input  wreq, sample, clr_flags,
    output ready, level, sample_tick, underrun, overflow, dac_out
  );

  modport master (
    output wreq, sample, clr_flags,
    input  ready, level, sample_tick, underrun, overflow, dac_out
  );
endinterface

// File: rtl/audio_dsm_fifo_out.sv
// Multi-channel PCM frame FIFO feeding first-order delta-sigma 1-bit DACs.
// Frames are queued through bus.wreq/bus.sample. A sample-rate divider raises
// sample_tick once per SAMPLE_DIV clocks; the IDLE/RUN state machine starts
// playback once PRIME_LEVEL frames are queued and then pops one frame per tick
// into the per-channel PCM registers. Each channel modulator converts its PCM
// value into a ones-density of pcm/2^AUDIO_BITS on bus.dac_out.
// Ports: clk (system clock), aclr_ (async active-low reset),
//        bus (audio_dsm_fifo_out_if.slave, see interface header).
// Option: define AUDIO_DSM_HOLD_LAST_EN to hold the last popped frame on
//         underrun instead of loading zero.
module audio_dsm_fifo_out #(
  parameter int unsigned AUDIO_BITS  = 12,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SAMPLE_DIV  = 4096,
  parameter int unsigned PRIME_LEVEL = FIFO_DEPTH / 2
) (
  input  logic                 clk,
  input  logic                 aclr_,
  audio_dsm_fifo_out_if.slave  bus
);
  localparam int unsigned FRAME_W = CHANNELS * AUDIO_BITS;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DIV_W   = $clog2(SAMPLE_DIV);
  localparam int unsigned ACC_W   = AUDIO_BITS + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIV_W-1:0]     r_div;
  logic                 r_tick;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic [LVL_W-1:0]     w_level_nxt;
  logic                 r_ready;
  logic                 r_underrun;
  logic                 r_overflow;
  logic [FRAME_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AUDIO_BITS-1:0] r_pcm [CHANNELS];
  logic [ACC_W-1:0]     r_acc [CHANNELS];
  logic [FRAME_W-1:0]   w_head;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  logic                 w_urun;

  // A write is only admitted against the registered ready, never a same-cycle pop.
  assign w_push = bus.wreq & r_ready;
  assign w_drop = bus.wreq & ~r_ready;
  assign w_head = r_mem[r_rd_ptr];

  // Sample-period divider; r_tick is high exactly while r_div == SAMPLE_DIV-1.
  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      if (r_div == DIV_W'(SAMPLE_DIV - 1)) r_div <= '0;
      else                                 r_div <= r_div + DIV_W'(1);
      r_tick <= (r_div == DIV_W'(SAMPLE_DIV - 2));
    end
  end

  // Playback state register.
  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and tick actions; decisions use the pre-push level so a frame
  // written in the tick cycle is never popped in that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_urun      = 1'b0;
    if (r_tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_level >= LVL_W'(PRIME_LEVEL)) begin
            w_pop       = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (r_level != '0) begin
            w_pop = 1'b1;
          end else begin
            w_urun      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LVL_W'(1);
    else if (w_pop && !w_push) w_level_nxt = r_level - LVL_W'(1);
  end

  // FIFO pointers, level, ready and sticky flags (set wins over clear).
  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_ready    <= 1'b1;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt < LVL_W'(FIFO_DEPTH));
      if (w_urun)             r_underrun <= 1'b1;
      else if (bus.clr_flags) r_underrun <= 1'b0;
      if (w_drop)             r_overflow <= 1'b1;
      else if (bus.clr_flags) r_overflow <= 1'b0;
    end
  end

  // Frame storage, not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.sample;
  end

  // PCM registers and first-order modulators; the carry out of the
  // accumulator is the 1-bit DAC output.
  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      for (int ch = 0; ch < int'(CHANNELS); ch++) begin
        r_pcm[ch] <= '0;
        r_acc[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < int'(CHANNELS); ch++) begin
        if (w_pop) begin
          r_pcm[ch] <= w_head[ch*AUDIO_BITS +: AUDIO_BITS];
        end
`ifndef AUDIO_DSM_HOLD_LAST_EN
        else if (w_urun) begin
          r_pcm[ch] <= '0;
        end
`endif
        r_acc[ch] <= {1'b0, r_acc[ch][AUDIO_BITS-1:0]} + {1'b0, r_pcm[ch]};
      end
    end
  end

  assign bus.ready       = r_ready;
  assign bus.level       = r_level;
  assign bus.sample_tick = r_tick;
  assign bus.underrun    = r_underrun;
  assign bus.overflow    = r_overflow;

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_dac
    assign bus.dac_out[g] = r_acc[g][AUDIO_BITS];
  end

endmodule
